// File: rtl/epu_sram_bus_router.sv
// epu_sram_bus_router
//   Switches NUM_BUSES single-port SRAM buses to one of NUM_UNITS compute units.
//   A registered mode-change handshake selects the owning unit. When ownership moves
//   from one unit to another, a DRAIN phase of RD_LAT cycles lets reads that are already
//   in flight return to the unit that issued them. Per-bus read tags steer R_data.
//   Per-unit clock enables drive the CG cells.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   mode_req/_valid/_ready          mode-change request handshake (0=IDLE, k=unit k-1)
//   mode_err                        1-cycle pulse after an out-of-range request is accepted
//   mode_cur, busy, unit_en         routed mode (0 if none), drain flag, one-hot unit enables
//   u_cs/u_oe/u_addr/u_W_req/u_W_data/u_R_data   unit side, index [(unit*NUM_BUSES+bus)*W +: W]
//   m_cs/m_oe/m_addr/m_W_req/m_W_data/m_R_data   memory side, index [bus*W +: W]
module epu_sram_bus_router #(
  parameter int NUM_UNITS = 3,
  parameter int NUM_BUSES = 5,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int WREQ_W    = 4,
  parameter logic [WREQ_W-1:0] WREQ_IDLE = '1,
  parameter int RD_LAT    = 1,
  // The mode field always has room for at least one out-of-range code, so a request
  // above NUM_UNITS can be expressed and reported through mode_err.
  localparam int MODE_W   = $clog2(NUM_UNITS + 2)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [MODE_W-1:0]                     mode_req,
  input  logic                                  mode_req_valid,
  output logic                                  mode_req_ready,
  output logic                                  mode_err,
  output logic [MODE_W-1:0]                     mode_cur,
  output logic                                  busy,
  output logic [NUM_UNITS-1:0]                  unit_en,
  input  logic [NUM_UNITS*NUM_BUSES-1:0]        u_cs,
  input  logic [NUM_UNITS*NUM_BUSES-1:0]        u_oe,
  input  logic [NUM_UNITS*NUM_BUSES*ADDR_W-1:0] u_addr,
  input  logic [NUM_UNITS*NUM_BUSES*WREQ_W-1:0] u_W_req,
  input  logic [NUM_UNITS*NUM_BUSES*DATA_W-1:0] u_W_data,
  output logic [NUM_UNITS*NUM_BUSES*DATA_W-1:0] u_R_data,
  output logic [NUM_BUSES-1:0]                  m_cs,
  output logic [NUM_BUSES-1:0]                  m_oe,
  output logic [NUM_BUSES*ADDR_W-1:0]           m_addr,
  output logic [NUM_BUSES*WREQ_W-1:0]           m_W_req,
  output logic [NUM_BUSES*DATA_W-1:0]           m_W_data,
  input  logic [NUM_BUSES*DATA_W-1:0]           m_R_data
);

  localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_UNITS);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} state_t;

  state_t               state, state_nxt;
  logic [UNIT_W-1:0]    cur_unit, cur_nxt;
  logic [MODE_W-1:0]    tgt_mode, tgt_nxt;
  logic [CNT_W-1:0]     drain_cnt, cnt_nxt;
  logic                 err_nxt;
  logic [NUM_UNITS-1:0] en_nxt;
  logic                 accept, legal;

  // Read tags: stage index i holds reads issued i+1 cycles ago.
  logic              tag_vld_p  [NUM_BUSES][RD_LAT];
  logic [UNIT_W-1:0] tag_unit_p [NUM_BUSES][RD_LAT];

  assign mode_req_ready = (state != ST_DRAIN);
  assign busy           = (state == ST_DRAIN);
  assign mode_cur       = (state == ST_ACTIVE) ? MODE_W'(cur_unit) + MODE_W'(1) : '0;
  assign accept         = mode_req_valid && mode_req_ready;
  assign legal          = (mode_req <= MAX_MODE);

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_unit;
    tgt_nxt   = tgt_mode;
    cnt_nxt   = drain_cnt;
    err_nxt   = accept && !legal;
    case (state)
      ST_IDLE: begin
        if (accept && legal && (mode_req != '0)) begin
          state_nxt = ST_ACTIVE;
          cur_nxt   = UNIT_W'(mode_req - MODE_W'(1));
        end
      end
      ST_ACTIVE: begin
        // Re-requesting the current mode is a no-op; anything else must drain first.
        if (accept && legal && (mode_req != MODE_W'(cur_unit) + MODE_W'(1))) begin
          state_nxt = ST_DRAIN;
          tgt_nxt   = mode_req;
          cnt_nxt   = CNT_W'(RD_LAT - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) begin
          if (tgt_mode == '0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_ACTIVE;
            cur_nxt   = UNIT_W'(tgt_mode - MODE_W'(1));
          end
        end else begin
          cnt_nxt = drain_cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // The old unit keeps its clock through DRAIN; cur_nxt already names the new unit
    // on the cycle ACTIVE is entered, so its enable rises together with the routing.
    for (int u = 0; u < NUM_UNITS; u++) begin
      en_nxt[u] = (state_nxt != ST_IDLE) && (cur_nxt == UNIT_W'(u));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_unit  <= '0;
      tgt_mode  <= '0;
      drain_cnt <= '0;
      mode_err  <= 1'b0;
      unit_en   <= '0;
    end else begin
      state     <= state_nxt;
      cur_unit  <= cur_nxt;
      tgt_mode  <= tgt_nxt;
      drain_cnt <= cnt_nxt;
      mode_err  <= err_nxt;
      unit_en   <= en_nxt;
    end
  end

  // Forward path: combinational mux from the owning unit, idle values otherwise.
  always_comb begin
    m_cs     = '0;
    m_oe     = '0;
    m_addr   = '0;
    m_W_data = '0;
    for (int b = 0; b < NUM_BUSES; b++) begin
      m_W_req[b*WREQ_W +: WREQ_W] = WREQ_IDLE;
    end
    if (state == ST_ACTIVE) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (cur_unit == UNIT_W'(u)) begin
          for (int b = 0; b < NUM_BUSES; b++) begin
            m_cs[b]                     = u_cs[u*NUM_BUSES+b];
            m_oe[b]                     = u_oe[u*NUM_BUSES+b];
            m_addr[b*ADDR_W +: ADDR_W]  = u_addr[(u*NUM_BUSES+b)*ADDR_W +: ADDR_W];
            m_W_req[b*WREQ_W +: WREQ_W] = u_W_req[(u*NUM_BUSES+b)*WREQ_W +: WREQ_W];
            m_W_data[b*DATA_W +: DATA_W] = u_W_data[(u*NUM_BUSES+b)*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Tag stage 0 <- issued read; stage i <- stage i-1
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BUSES; b++) begin
      if (rst) begin
        for (int i = 0; i < RD_LAT; i++) tag_vld_p[b][i] <= 1'b0;
      end else begin
        tag_vld_p[b][0] <= m_cs[b] & m_oe[b];
        for (int i = 1; i < RD_LAT; i++) tag_vld_p[b][i] <= tag_vld_p[b][i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BUSES; b++) begin
      tag_unit_p[b][0] <= cur_unit;
      for (int i = 1; i < RD_LAT; i++) tag_unit_p[b][i] <= tag_unit_p[b][i-1];
    end
  end

  // Tag exit stage: returning data goes only to the unit that issued the read
  always_comb begin
    u_R_data = '0;
    for (int b = 0; b < NUM_BUSES; b++) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (tag_vld_p[b][RD_LAT-1] && (tag_unit_p[b][RD_LAT-1] == UNIT_W'(u))) begin
          u_R_data[(u*NUM_BUSES+b)*DATA_W +: DATA_W] = m_R_data[b*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_epu_sram_bus_router.sv
module tb_epu_sram_bus_router;
  localparam int NU = 3, NB = 5, AW = 32, DW = 32, WW = 4, LAT = 3;
  localparam int MW = $clog2(NU + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [MW-1:0]       mode_req = '0;
  logic                mode_req_valid = 1'b0;
  logic                mode_req_ready, mode_err, busy;
  logic [MW-1:0]       mode_cur;
  logic [NU-1:0]       unit_en;
  logic [NU*NB-1:0]    u_cs = '0, u_oe = '0;
  logic [NU*NB*AW-1:0] u_addr = '0;
  logic [NU*NB*WW-1:0] u_W_req = '0;
  logic [NU*NB*DW-1:0] u_W_data = '0;
  logic [NU*NB*DW-1:0] u_R_data;
  logic [NB-1:0]       m_cs, m_oe;
  logic [NB*AW-1:0]    m_addr;
  logic [NB*WW-1:0]    m_W_req;
  logic [NB*DW-1:0]    m_W_data;
  logic [NB*DW-1:0]    m_R_data = '0;

  epu_sram_bus_router #(
    .NUM_UNITS(NU), .NUM_BUSES(NB), .ADDR_W(AW), .DATA_W(DW), .WREQ_W(WW),
    .WREQ_IDLE(4'hF), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
    .mode_err(mode_err), .mode_cur(mode_cur), .busy(busy), .unit_en(unit_en),
    .u_cs(u_cs), .u_oe(u_oe), .u_addr(u_addr), .u_W_req(u_W_req), .u_W_data(u_W_data),
    .u_R_data(u_R_data),
    .m_cs(m_cs), .m_oe(m_oe), .m_addr(m_addr), .m_W_req(m_W_req), .m_W_data(m_W_data),
    .m_R_data(m_R_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {S_CUR, S_EN, S_BUSY, S_RDY, S_ERR, S_CS, S_ADDR, S_WREQ, S_WDATA, S_ROR} sig_e;
  typedef struct {int cyc; sig_e sig; int idx; logic [31:0] val; string name;} exp_t;
  typedef struct {int cyc; int unit; int bus; logic [31:0] data;} rd_t;
  exp_t ctl_q[$];
  rd_t  rd_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] peek(sig_e s, int i);
    case (s)
      S_CUR:   return 32'(mode_cur);
      S_EN:    return 32'(unit_en);
      S_BUSY:  return 32'(busy);
      S_RDY:   return 32'(mode_req_ready);
      S_ERR:   return 32'(mode_err);
      S_CS:    return 32'(m_cs[i]);
      S_ADDR:  return m_addr[i*AW +: AW];
      S_WREQ:  return 32'(m_W_req[i*WW +: WW]);
      S_WDATA: return m_W_data[i*DW +: DW];
      S_ROR:   return 32'(|u_R_data);
      default: return '0;
    endcase
  endfunction

  // Expected value for a signal in the current cycle.
  task automatic expect_now(input sig_e s, input int i, input logic [31:0] v, input string n);
    exp_t e;
    e = '{cyc, s, i, v, n};
    ctl_q.push_back(e);
  endtask

  task automatic expect_read(input int u, input int b, input logic [31:0] d);
    rd_t r;
    r = '{cyc, u, b, d};
    rd_q.push_back(r);
  endtask

  // Monitor: compares control expectations due this cycle and every R_data delivery.
  always @(negedge clk) begin
    exp_t e;
    rd_t r;
    logic [31:0] got;
    logic [DW-1:0] slice;
    while (ctl_q.size() > 0 && ctl_q[0].cyc <= cyc) begin
      e = ctl_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not evaluated (now %0d)", e.name, e.cyc, cyc);
      end else begin
        got = peek(e.sig, e.idx);
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", e.name, cyc, got, e.val);
        end
      end
    end
    if (cyc >= 1) begin
      for (int u = 0; u < NU; u++) begin
        for (int b = 0; b < NB; b++) begin
          slice = u_R_data[(u*NB+b)*DW +: DW];
          if (slice !== '0) begin
            checks++;
            if (rd_q.size() == 0) begin
              errors++;
              $display("FAIL rdata_unexpected @cyc %0d: unit %0d bus %0d got 0x%0h expected none", cyc, u, b, slice);
            end else begin
              r = rd_q.pop_front();
              if (r.cyc != cyc || r.unit != u || r.bus != b || r.data !== slice) begin
                errors++;
                $display("FAIL rdata @cyc %0d: got unit %0d bus %0d 0x%0h, expected cyc %0d unit %0d bus %0d 0x%0h",
                         cyc, u, b, slice, r.cyc, r.unit, r.bus, r.data);
              end
            end
          end
        end
      end
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        r = rd_q.pop_front();
        checks++;
        errors++;
        $display("FAIL rdata_missing: unit %0d bus %0d 0x%0h expected @cyc %0d, got nothing", r.unit, r.bus, r.data, r.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m);
    mode_req = MW'(m);
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
  endtask

  task automatic set_bus(input int u, input int b, input logic cs, input logic oe,
                         input logic [AW-1:0] addr, input logic [WW-1:0] wreq,
                         input logic [DW-1:0] wdata);
    u_cs[u*NB+b] = cs;
    u_oe[u*NB+b] = oe;
    u_addr[(u*NB+b)*AW +: AW]   = addr;
    u_W_req[(u*NB+b)*WW +: WW]  = wreq;
    u_W_data[(u*NB+b)*DW +: DW] = wdata;
  endtask

  task automatic clr_units();
    u_cs = '0; u_oe = '0; u_addr = '0; u_W_req = '0; u_W_data = '0;
  endtask

  task automatic drive_rd(input int b, input logic [DW-1:0] d);
    m_R_data = '0;
    m_R_data[b*DW +: DW] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    tick();
    expect_now(S_CUR, 0, 32'd0, "rst_mode_cur");
    expect_now(S_EN, 0, 32'd0, "rst_unit_en");
    expect_now(S_RDY, 0, 32'd1, "rst_ready");
    expect_now(S_BUSY, 0, 32'd0, "rst_busy");
    expect_now(S_ERR, 0, 32'd0, "rst_err");
    expect_now(S_CS, 0, 32'd0, "rst_m_cs0");
    expect_now(S_ADDR, 1, 32'd0, "rst_m_addr1");
    expect_now(S_WREQ, 3, 32'hF, "rst_m_wreq3");
    expect_now(S_ROR, 0, 32'd0, "rst_rdata");
    tick();
    rst = 1'b0;
    tick();

    // 1: IDLE -> ACTIVE(u0), read on bus2 returns to u0 only
    req(1);
    expect_now(S_CUR, 0, 32'd1, "t1_mode_cur");
    expect_now(S_EN, 0, 32'b001, "t1_unit_en");
    expect_now(S_BUSY, 0, 32'd0, "t1_busy");
    set_bus(0, 2, 1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
    expect_now(S_CS, 2, 32'd1, "t1_m_cs2");
    expect_now(S_ADDR, 2, 32'h40, "t1_m_addr2");
    expect_now(S_CS, 0, 32'd0, "t1_m_cs0");
    tick();
    clr_units();
    tick();
    tick();
    drive_rd(2, 32'hDEAD_BEEF);
    expect_read(0, 2, 32'hDEAD_BEEF);
    tick();
    m_R_data = '0;

    // 2: read issued in the same cycle as a switch to u1; data drains back to u0
    set_bus(0, 0, 1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
    req(2);
    expect_now(S_BUSY, 0, 32'd1, "t2_busy");
    expect_now(S_RDY, 0, 32'd0, "t2_ready");
    expect_now(S_CUR, 0, 32'd0, "t2_mode_cur_drain");
    expect_now(S_EN, 0, 32'b001, "t2_unit_en_drain");
    expect_now(S_CS, 0, 32'd0, "t2_m_cs0_drain");
    tick();
    clr_units();
    expect_now(S_BUSY, 0, 32'd1, "t2_busy_mid");
    tick();
    drive_rd(0, 32'h1234_5678);
    expect_read(0, 0, 32'h1234_5678);
    expect_now(S_EN, 0, 32'b001, "t2_unit_en_return");
    tick();
    m_R_data = '0;
    expect_now(S_CUR, 0, 32'd2, "t2_mode_cur_new");
    expect_now(S_EN, 0, 32'b010, "t2_unit_en_new");
    expect_now(S_BUSY, 0, 32'd0, "t2_busy_done");
    expect_now(S_RDY, 0, 32'd1, "t2_ready_done");

    // 3: move to u2, then an out-of-range request
    req(3);
    tick(); tick(); tick();
    expect_now(S_CUR, 0, 32'd3, "t3_mode_cur");
    expect_now(S_EN, 0, 32'b100, "t3_unit_en");
    req(4);
    expect_now(S_ERR, 0, 32'd1, "t3_err_pulse");
    expect_now(S_CUR, 0, 32'd3, "t3_mode_cur_kept");
    expect_now(S_BUSY, 0, 32'd0, "t3_no_drain");
    expect_now(S_EN, 0, 32'b100, "t3_unit_en_kept");
    set_bus(2, 4, 1'b1, 1'b0, 32'hAB, 4'b0011, 32'hCAFE_0001);
    set_bus(0, 4, 1'b1, 1'b1, 32'h99, 4'b1100, 32'h1111_1111);
    expect_now(S_CS, 4, 32'd1, "t3_m_cs4");
    expect_now(S_ADDR, 4, 32'hAB, "t3_m_addr4");
    expect_now(S_WREQ, 4, 32'h3, "t3_m_wreq4");
    expect_now(S_WDATA, 4, 32'hCAFE_0001, "t3_m_wdata4");
    tick();
    expect_now(S_ERR, 0, 32'd0, "t3_err_cleared");
    expect_now(S_CUR, 0, 32'd3, "t3_mode_cur_after");

    // 6: same-mode request is a no-op; request 0 drains to IDLE
    req(3);
    expect_now(S_BUSY, 0, 32'd0, "t6_same_no_drain");
    expect_now(S_EN, 0, 32'b100, "t6_same_unit_en");
    expect_now(S_CUR, 0, 32'd3, "t6_same_mode_cur");
    expect_now(S_WREQ, 4, 32'h3, "t6_same_m_wreq4");
    req(0);
    expect_now(S_BUSY, 0, 32'd1, "t6_idle_drain");
    expect_now(S_EN, 0, 32'b100, "t6_drain_unit_en");
    expect_now(S_WREQ, 4, 32'hF, "t6_drain_m_wreq4");
    expect_now(S_CS, 4, 32'd0, "t6_drain_m_cs4");
    expect_now(S_CUR, 0, 32'd0, "t6_drain_mode_cur");
    tick(); tick();
    expect_now(S_EN, 0, 32'b100, "t6_drain_end_unit_en");
    tick();
    expect_now(S_CUR, 0, 32'd0, "t6_idle_mode_cur");
    expect_now(S_EN, 0, 32'd0, "t6_idle_unit_en");
    expect_now(S_BUSY, 0, 32'd0, "t6_idle_busy");
    expect_now(S_WREQ, 4, 32'hF, "t6_idle_m_wreq4");
    clr_units();

    // 4: request held during a 3-cycle drain is accepted afterwards
    req(1);
    req(2);
    mode_req = MW'(3);
    mode_req_valid = 1'b1;
    expect_now(S_RDY, 0, 32'd0, "t4_ready_d0");
    tick();
    expect_now(S_RDY, 0, 32'd0, "t4_ready_d1");
    tick();
    expect_now(S_RDY, 0, 32'd0, "t4_ready_d2");
    tick();
    expect_now(S_RDY, 0, 32'd1, "t4_ready_back");
    expect_now(S_CUR, 0, 32'd2, "t4_mode_cur_u1");
    expect_now(S_EN, 0, 32'b010, "t4_unit_en_u1");
    tick();
    mode_req_valid = 1'b0;
    expect_now(S_BUSY, 0, 32'd1, "t4_held_req_drain");
    expect_now(S_EN, 0, 32'b010, "t4_held_unit_en");
    tick(); tick(); tick();
    expect_now(S_CUR, 0, 32'd3, "t4_mode_cur_u2");
    expect_now(S_EN, 0, 32'b100, "t4_unit_en_u2");

    // 5: reset in the middle of DRAIN with a read tag pending
    set_bus(2, 1, 1'b1, 1'b1, 32'h77, 4'h0, 32'h0);
    req(1);
    clr_units();
    expect_now(S_BUSY, 0, 32'd1, "t5_busy_pre_rst");
    rst = 1'b1;
    tick();
    expect_now(S_BUSY, 0, 32'd0, "t5_rst_busy");
    expect_now(S_RDY, 0, 32'd1, "t5_rst_ready");
    expect_now(S_CUR, 0, 32'd0, "t5_rst_mode_cur");
    expect_now(S_EN, 0, 32'd0, "t5_rst_unit_en");
    expect_now(S_ERR, 0, 32'd0, "t5_rst_err");
    expect_now(S_ROR, 0, 32'd0, "t5_rst_rdata");
    rst = 1'b0;
    tick();
    drive_rd(1, 32'h5555_AAAA);
    expect_now(S_ROR, 0, 32'd0, "t5_tag_discarded");
    tick();
    m_R_data = '0;
    req(2);
    expect_now(S_CUR, 0, 32'd2, "t5_after_rst_mode_cur");
    expect_now(S_EN, 0, 32'b010, "t5_after_rst_unit_en");
    tick();
    tick();

    foreach (ctl_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: pending expectation for cycle %0d, got no evaluation", ctl_q[i].name, ctl_q[i].cyc);
    end
    foreach (rd_q[i]) begin
      checks++;
      errors++;
      $display("FAIL rdata_pending: unit %0d bus %0d expected 0x%0h, got nothing", rd_q[i].unit, rd_q[i].bus, rd_q[i].data);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
